// File: rtl/filter_shaper_pkg.sv
// Shared types and sizing constants for the filter_shaper slot.
package filter_shaper_pkg;

    localparam int SIZE_ADC_DATA     = 12;
    localparam int SIZE_FILTER_DATA  = 20;
    localparam int FILTER_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_DD     = 2'b01,
        MODE_SUM    = 2'b10,
        MODE_RSVD   = 2'b11
    } filt_mode_t;

    typedef enum logic {
        ST_FLUSH,
        ST_RUN
    } filt_state_t;

    typedef enum logic {
        PK_BELOW,
        PK_ABOVE
    } peak_state_t;

    // Smallest output width that cannot overflow a full-window moving sum.
    function automatic int min_out_width(int size_in, int depth_log2);
        return size_in + depth_log2 + 1;
    endfunction

endpackage

// File: rtl/filter_shaper_if.sv
// Config, sample and result bundle between a filter slot and its driver.
interface filter_shaper_if #(
    parameter int SIZE_IN    = 12,
    parameter int SIZE_OUT   = 20,
    parameter int DEPTH_LOG2 = 4
);

    logic                  cfg_load;
    logic [1:0]            mode;
    logic [DEPTH_LOG2-1:0] delay_k;
    logic [SIZE_OUT-1:0]   threshold;
    logic                  input_valid;
    logic [SIZE_IN-1:0]    input_data;
    logic                  busy;
    logic                  output_valid;
    logic [SIZE_OUT-1:0]   output_data;
    logic                  peak_valid;
    logic [SIZE_OUT-1:0]   peak_data;

    modport master (
        output cfg_load,
        output mode,
        output delay_k,
        output threshold,
        output input_valid,
        output input_data,
        input  busy,
        input  output_valid,
        input  output_data,
        input  peak_valid,
        input  peak_data
    );

    modport slave (
        input  cfg_load,
        input  mode,
        input  delay_k,
        input  threshold,
        input  input_valid,
        input  input_data,
        output busy,
        output output_valid,
        output output_data,
        output peak_valid,
        output peak_data
    );

endinterface

// File: rtl/filter_shaper_delay_line.sv
// Circular sample buffer with k-tap read and a flush write port.
module filter_shaper_delay_line #(
    parameter int SIZE_IN    = 12,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [SIZE_IN-1:0]    din,
    input  logic [DEPTH_LOG2-1:0] k,
    input  logic                  flush_we,
    input  logic [DEPTH_LOG2-1:0] flush_addr,
    output logic [SIZE_IN-1:0]    tap
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [SIZE_IN-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rd_addr;

    // Modular subtraction gives the wrap-around tap for free.
    assign rd_addr = wp - k;
    assign tap     = mem[rd_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_we) begin
            mem[flush_addr] <= '0;
        end else if (push) begin
            mem[wp] <= din;
            wp      <= wp + 1'b1;
        end
    end

endmodule

// File: rtl/filter_shaper.sv
// Runtime-configurable shaping filter: bypass, delay-difference, moving sum,
// followed by a threshold peak detector.
module filter_shaper
    import filter_shaper_pkg::*;
#(
    parameter int SIZE_IN    = SIZE_ADC_DATA,
    parameter int SIZE_OUT   = SIZE_FILTER_DATA,
    parameter int DEPTH_LOG2 = FILTER_DEPTH_LOG2
) (
    input logic           clk,
    input logic           reset,
    filter_shaper_if.slave bus
);

    if (SIZE_OUT < min_out_width(SIZE_IN, DEPTH_LOG2)) begin : g_width_check
        $error("filter_shaper: SIZE_OUT too narrow for SIZE_IN and DEPTH_LOG2");
    end

    localparam logic [DEPTH_LOG2-1:0] CNT_LAST = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2-1:0] K_ONE    =
        {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    filt_state_t           state;
    filt_state_t           state_nxt;
    logic [DEPTH_LOG2-1:0] cnt;
    logic [DEPTH_LOG2-1:0] cnt_nxt;
    filt_mode_t            cfg_mode;
    logic [DEPTH_LOG2-1:0] cfg_k;

    logic                  flushing;
    logic                  accept;
    logic                  kill;
    logic [SIZE_IN-1:0]    tap;

    logic                  s1_valid;
    logic signed [SIZE_OUT-1:0] s1_x;
    logic signed [SIZE_OUT-1:0] s1_tap;
    filt_mode_t            s1_mode;

    logic signed [SIZE_OUT-1:0] acc;
    logic signed [SIZE_OUT-1:0] acc_nxt;
    logic signed [SIZE_OUT-1:0] y;
    logic                  out_valid;
    logic signed [SIZE_OUT-1:0] out_data;

    peak_state_t           pk_state;
    peak_state_t           pk_nxt;
    logic signed [SIZE_OUT-1:0] pk_max;
    logic signed [SIZE_OUT-1:0] max_nxt;
    logic                  above;
    logic                  pulse;
    logic                  peak_valid;
    logic signed [SIZE_OUT-1:0] peak_data;

    assign flushing = (state == ST_FLUSH);
    assign accept   = (state == ST_RUN) & bus.input_valid & ~bus.cfg_load;
    // Anything in flight when a flush starts is dropped, not emitted.
    assign kill     = flushing | bus.cfg_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FLUSH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_FLUSH: begin
                if (bus.cfg_load) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.cfg_load) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_mode <= MODE_BYPASS;
            cfg_k    <= K_ONE;
        end else if (bus.cfg_load) begin
            cfg_mode <= filt_mode_t'(bus.mode);
            cfg_k    <= (bus.delay_k == '0) ? K_ONE : bus.delay_k;
        end
    end

    filter_shaper_delay_line #(
        .SIZE_IN    (SIZE_IN),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_delay_line (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .din        (bus.input_data),
        .k          (cfg_k),
        .flush_we   (flushing),
        .flush_addr (cnt),
        .tap        (tap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_tap   <= '0;
            s1_mode  <= MODE_BYPASS;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_x    <= {{(SIZE_OUT-SIZE_IN){1'b0}}, bus.input_data};
                s1_tap  <= {{(SIZE_OUT-SIZE_IN){1'b0}}, tap};
                s1_mode <= cfg_mode;
            end
        end
    end

    always_comb begin
        y       = s1_x;
        acc_nxt = acc;
        unique case (1'b1)
            s1_mode == MODE_DD: y = s1_x - s1_tap;
            s1_mode == MODE_SUM: begin
                acc_nxt = acc + s1_x - s1_tap;
                y       = acc_nxt;
            end
            default: y = s1_x;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
        end else if (kill) begin
            out_valid <= 1'b0;
            acc       <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= y;
                acc      <= acc_nxt;
            end
        end
    end

    always_comb begin
        pk_nxt  = pk_state;
        max_nxt = pk_max;
        pulse   = 1'b0;
        above   = out_data > $signed(bus.threshold);
        if (kill) begin
            pk_nxt = PK_BELOW;
        end else if (out_valid) begin
            unique case (pk_state)
                PK_BELOW: begin
                    if (above) begin
                        pk_nxt  = PK_ABOVE;
                        max_nxt = out_data;
                    end
                end
                PK_ABOVE: begin
                    if (above) begin
                        if (out_data > pk_max) begin
                            max_nxt = out_data;
                        end
                    end else begin
                        pulse  = 1'b1;
                        pk_nxt = PK_BELOW;
                    end
                end
                default: pk_nxt = PK_BELOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pk_state   <= PK_BELOW;
            pk_max     <= '0;
            peak_valid <= 1'b0;
            peak_data  <= '0;
        end else begin
            pk_state   <= pk_nxt;
            pk_max     <= max_nxt;
            peak_valid <= pulse;
            if (pulse) begin
                peak_data <= pk_max;
            end
        end
    end

    assign bus.busy         = flushing;
    assign bus.output_valid = out_valid;
    assign bus.output_data  = out_data;
    assign bus.peak_valid   = peak_valid;
    assign bus.peak_data    = peak_data;

endmodule

// File: tb/tb_filter_shaper.sv
// Randomized bench for filter_shaper against a sample-history model.
module tb_filter_shaper;
    import filter_shaper_pkg::*;

    localparam int SI    = 12;
    localparam int SO    = 20;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        int due;
        int val;
    } item_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    filter_shaper_if #(.SIZE_IN(SI), .SIZE_OUT(SO), .DEPTH_LOG2(DL)) bus ();

    filter_shaper #(
        .SIZE_IN    (SI),
        .SIZE_OUT   (SO),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    edge_no  = 0;
    int    flush_left;
    int    m_mode;
    int    m_k;
    int    hist[$];
    item_t sched[$];
    int    exp_ov, exp_od, exp_pv, exp_pd;
    int    pk_above, pk_max, prev_ov, prev_od;
    int    thr = 0;

    task automatic check(string tag, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     tag, got, exp, edge_no);
        end
    endtask

    task automatic model_reset();
        flush_left = DEPTH;
        m_mode     = 0;
        m_k        = 1;
        hist.delete();
        sched.delete();
        exp_ov   = 0;
        exp_od   = 0;
        exp_pv   = 0;
        exp_pd   = 0;
        pk_above = 0;
        pk_max   = 0;
        prev_ov  = 0;
        prev_od  = 0;
    endtask

    // Sample 'back' positions before the newest one; zero before the flush.
    function automatic int hist_at(int back);
        int idx;
        idx = hist.size() - 1 - back;
        return (idx >= 0) ? hist[idx] : 0;
    endfunction

    function automatic int filter_value();
        int s;
        s = 0;
        case (m_mode)
            1: s = hist_at(0) - hist_at(m_k);
            2: for (int i = 0; i < m_k; i++) s += hist_at(i);
            default: s = hist_at(0);
        endcase
        return s;
    endfunction

    task automatic model_edge(bit cfg, int mode, int k, bit v, int d);
        edge_no++;
        exp_pv = 0;
        if (cfg) begin
            pk_above = 0;
        end else if (prev_ov != 0) begin
            if (prev_od > thr) begin
                if (pk_above == 0 || prev_od > pk_max) pk_max = prev_od;
                pk_above = 1;
            end else if (pk_above != 0) begin
                exp_pv   = 1;
                exp_pd   = pk_max;
                pk_above = 0;
            end
        end
        if (cfg) begin
            m_mode     = mode;
            m_k        = (k == 0) ? 1 : k;
            flush_left = DEPTH;
            hist.delete();
            sched.delete();
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (v) begin
            hist.push_back(d);
            sched.push_back('{edge_no + 1, filter_value()});
        end
        prev_ov = 0;
        if (sched.size() > 0 && sched[0].due == edge_no) begin
            prev_ov = 1;
            prev_od = sched[0].val;
            exp_od  = prev_od;
            void'(sched.pop_front());
        end
        exp_ov = prev_ov;
    endtask

    task automatic compare();
        check("busy", int'(bus.busy), int'(flush_left > 0));
        check("output_valid", int'(bus.output_valid), exp_ov);
        check("output_data", $signed(bus.output_data), exp_od);
        check("peak_valid", int'(bus.peak_valid), exp_pv);
        check("peak_data", $signed(bus.peak_data), exp_pd);
    endtask

    task automatic step(bit cfg, int mode, int k, bit v, int d);
        bus.cfg_load    = cfg;
        bus.mode        = mode[1:0];
        bus.delay_k     = k[DL-1:0];
        bus.input_valid = v;
        bus.input_data  = d[SI-1:0];
        bus.threshold   = thr[SO-1:0];
        @(posedge clk);
        model_edge(cfg, mode, k, v, d);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        bus.cfg_load    = 1'b0;
        bus.input_valid = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        compare();
        repeat (cycles) @(negedge clk);
        compare();
        reset = 1'b1;
    endtask

    initial begin
        reset           = 1'b1;
        bus.cfg_load    = 1'b0;
        bus.mode        = 2'b00;
        bus.delay_k     = '0;
        bus.threshold   = '0;
        bus.input_valid = 1'b0;
        bus.input_data  = '0;
        model_reset();
        do_reset(3);

        // Power-up flush then bypass tracking.
        thr = 1 << 18;
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1, $urandom_range(0, 4095));

        // Delay-difference on a constant.
        step(1, 1, 4, 0, 0);
        idle(DEPTH);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 100);
        idle(3);

        // Moving sum on a step, dense and with gaps.
        step(1, 2, 4, 0, 0);
        idle(DEPTH);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 1, (i < 8) ? 100 : 0);
        idle(3);
        step(1, 2, 4, 0, 0);
        idle(DEPTH);
        for (int i = 0; i < 28; i++) step(0, 0, 0, (i % 2) == 0, (i < 16) ? 100 : 0);
        idle(3);

        // Single excursion through the peak detector.
        thr = 50;
        step(1, 1, 2, 0, 0);
        idle(DEPTH);
        begin
            int seq[7] = '{0, 0, 80, 120, 120, 0, 0};
            foreach (seq[i]) step(0, 0, 0, 1, seq[i]);
        end
        idle(4);

        // Reconfigure while above threshold, then reset mid-stream.
        thr = 150;
        step(1, 2, 4, 0, 0);
        idle(DEPTH);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 100);
        step(1, 2, 4, 1, 100);
        idle(DEPTH + 2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 200);
        do_reset(2);
        idle(DEPTH + 2);

        for (int r = 0; r < 10; r++) begin
            thr = int'($urandom_range(0, 12000)) - 2000;
            step(1, $urandom_range(0, 3), $urandom_range(0, 15), 0, 0);
            idle($urandom_range(0, DEPTH + 2));
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 99) == 0)
                    step(1, $urandom_range(0, 3), $urandom_range(0, 15), 1, 0);
                else
                    step(0, 0, 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4095));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
